// File: rtl/bcd_to_binary.sv
// Sequential reverse double-dabble: packed BCD in, unsigned binary out.
// One conversion at a time; i_Start accepted only in IDLE, o_DV strobes one cycle.
//
// state             | meaning
// IDLE              | waiting for i_Start, latches operand
// SHIFT             | shift {bcd_reg, bin_reg} right one bit (invalid digits caught on first pass)
// SUB               | correct current digit: >= 8 -> minus 3
// CHECK_DIGIT_INDEX | advance to next digit or finish the digit sweep
// CHECK_SHIFT_INDEX | advance to next shift or finish the conversion
// DONE              | publish result, flags and strobe

module bcd_to_binary #(
    parameter int DECIMAL_DIGITS = 2,
    parameter int OUTPUT_WIDTH   = 7
) (
    input  logic                        i_Clock,
    input  logic                        i_Reset,
    input  logic [DECIMAL_DIGITS*4-1:0] i_BCD,
    input  logic                        i_Start,
    output logic [OUTPUT_WIDTH-1:0]     o_Binary,
    output logic                        o_DV,
    output logic                        o_Busy,
    output logic                        o_Err,
    output logic                        o_Ovf
);

    localparam int BCD_W = DECIMAL_DIGITS * 4;
    localparam int IDX_W = (DECIMAL_DIGITS > 1) ? $clog2(DECIMAL_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DECIMAL_DIGITS - 1);
    localparam logic [7:0]       LAST_LOOP = 8'(OUTPUT_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        SUB,
        CHECK_DIGIT_INDEX,
        CHECK_SHIFT_INDEX,
        DONE
    } state_t;

    state_t                  state, state_next;
    logic [BCD_W-1:0]        bcd_reg, bcd_next;
    logic [OUTPUT_WIDTH-1:0] bin_reg, bin_next;
    logic [IDX_W-1:0]        idx, idx_next;
    logic [7:0]              loop_cnt, loop_next;
    logic [OUTPUT_WIDTH-1:0] binary_next;
    logic                    dv_next, err_next, ovf_next;

    function automatic logic has_bad_digit(input logic [BCD_W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int d = 0; d < DECIMAL_DIGITS; d++) begin
            if (v[d*4 +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state    <= IDLE;
            bcd_reg  <= '0;
            bin_reg  <= '0;
            idx      <= '0;
            loop_cnt <= '0;
            o_Binary <= '0;
            o_DV     <= 1'b0;
            o_Err    <= 1'b0;
            o_Ovf    <= 1'b0;
        end else begin
            state    <= state_next;
            bcd_reg  <= bcd_next;
            bin_reg  <= bin_next;
            idx      <= idx_next;
            loop_cnt <= loop_next;
            o_Binary <= binary_next;
            o_DV     <= dv_next;
            o_Err    <= err_next;
            o_Ovf    <= ovf_next;
        end
    end

    always_comb begin
        state_next  = state;
        bcd_next    = bcd_reg;
        bin_next    = bin_reg;
        idx_next    = idx;
        loop_next   = loop_cnt;
        binary_next = o_Binary;
        dv_next     = 1'b0;
        err_next    = o_Err;
        ovf_next    = o_Ovf;

        case (state)
            IDLE: begin
                if (i_Start) begin
                    bcd_next   = i_BCD;
                    bin_next   = '0;
                    err_next   = 1'b0;
                    ovf_next   = 1'b0;
                    idx_next   = '0;
                    loop_next  = '0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                // Only the first pass can see a non-decimal digit; later digits are always corrected to 0..9
                if (loop_cnt == 8'd0 && has_bad_digit(bcd_reg)) begin
                    err_next   = 1'b1;
                    state_next = DONE;
                end else begin
                    bin_next   = OUTPUT_WIDTH'({bcd_reg[0], bin_reg} >> 1);
                    bcd_next   = bcd_reg >> 1;
                    idx_next   = '0;
                    state_next = SUB;
                end
            end
            SUB: begin
                for (int d = 0; d < DECIMAL_DIGITS; d++) begin
                    if (d == int'(idx) && bcd_reg[d*4 +: 4] >= 4'd8)
                        bcd_next[d*4 +: 4] = bcd_reg[d*4 +: 4] - 4'd3;
                end
                state_next = CHECK_DIGIT_INDEX;
            end
            CHECK_DIGIT_INDEX: begin
                if (idx == LAST_IDX) begin
                    idx_next   = '0;
                    state_next = CHECK_SHIFT_INDEX;
                end else begin
                    idx_next   = idx + 1'b1;
                    state_next = SUB;
                end
            end
            CHECK_SHIFT_INDEX: begin
                if (loop_cnt == LAST_LOOP) begin
                    loop_next  = '0;
                    state_next = DONE;
                end else begin
                    loop_next  = loop_cnt + 8'd1;
                    state_next = SHIFT;
                end
            end
            DONE: begin
                binary_next = bin_reg;
                ovf_next    = o_Err ? 1'b0 : (bcd_reg != '0);
                dv_next     = 1'b1;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign o_Busy = (state != IDLE);

endmodule

// File: tb/tb_bcd_to_binary.sv
// Scoreboard bench for bcd_to_binary: default instance (7-bit) and a 6-bit instance for overflow.
`timescale 1ns/1ps
module tb_bcd_to_binary;

    typedef struct {
        logic [6:0] bin;
        logic       err;
        logic       ovf;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] bcd7 = '0, bcd6 = '0;
    logic       start7 = 1'b0, start6 = 1'b0;
    logic [6:0] bin7;
    logic [5:0] bin6;
    logic       dv7, busy7, err7, ovf7;
    logic       dv6, busy6, err6, ovf6;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q7[$];
    exp_t q6[$];

    bcd_to_binary #(.DECIMAL_DIGITS(2), .OUTPUT_WIDTH(7)) dut (
        .i_Clock(clk), .i_Reset(rst), .i_BCD(bcd7), .i_Start(start7),
        .o_Binary(bin7), .o_DV(dv7), .o_Busy(busy7), .o_Err(err7), .o_Ovf(ovf7)
    );

    bcd_to_binary #(.DECIMAL_DIGITS(2), .OUTPUT_WIDTH(6)) dut6 (
        .i_Clock(clk), .i_Reset(rst), .i_BCD(bcd6), .i_Start(start6),
        .o_Binary(bin6), .o_DV(dv6), .o_Busy(busy6), .o_Err(err6), .o_Ovf(ovf6)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon7();
        exp_t e;
        forever begin
            @(negedge clk);
            if (dv7 === 1'b1) begin
                if (q7.size() == 0) chk("unexpected_dv7", int'(dv7), 0);
                else begin
                    e = q7.pop_front();
                    chk("bin7", int'(bin7), int'(e.bin));
                    chk("err7", int'(err7), int'(e.err));
                    chk("ovf7", int'(ovf7), int'(e.ovf));
                    chk("latency7", cyc, e.cyc);
                end
            end
        end
    endtask

    task automatic mon6();
        exp_t e;
        forever begin
            @(negedge clk);
            if (dv6 === 1'b1) begin
                if (q6.size() == 0) chk("unexpected_dv6", int'(dv6), 0);
                else begin
                    e = q6.pop_front();
                    chk("bin6", int'({1'b0, bin6}), int'(e.bin));
                    chk("err6", int'(err6), int'(e.err));
                    chk("ovf6", int'(ovf6), int'(e.ovf));
                    chk("latency6", cyc, e.cyc);
                end
            end
        end
    endtask

    // Called at a negedge; returns at the negedge following the start edge E0.
    task automatic go(input bit w6, input logic [7:0] bcd, input int bin,
                      input bit err, input bit ovf, input int lat);
        exp_t e;
        if (w6) begin bcd6 = bcd; start6 = 1'b1; end
        else    begin bcd7 = bcd; start7 = 1'b1; end
        @(posedge clk);
        @(negedge clk);
        start6 = 1'b0;
        start7 = 1'b0;
        e.bin = 7'(bin);
        e.err = err;
        e.ovf = ovf;
        e.cyc = cyc + lat;
        if (w6) q6.push_back(e);
        else    q7.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while ((q7.size() + q6.size()) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if ((q7.size() + q6.size()) != 0) begin
            chk("drain_timeout", q7.size() + q6.size(), 0);
            q7.delete();
            q6.delete();
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_bin"},  int'(bin7),  0);
        chk({tag, "_dv"},   int'(dv7),   0);
        chk({tag, "_busy"}, int'(busy7), 0);
        chk({tag, "_err"},  int'(err7),  0);
        chk({tag, "_ovf"},  int'(ovf7),  0);
    endtask

    initial begin
        int n;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        chk("reset_busy6", int'(busy6), 0);
        rst = 1'b0;
        @(negedge clk);

        fork
            mon7();
            mon6();
        join_none

        // Basic 42 with busy window
        go(0, 8'h42, 42, 0, 0, 43);
        @(negedge clk);
        chk("busy_e1", int'(busy7), 1);
        repeat (41) @(negedge clk);
        chk("busy_e42", int'(busy7), 1);
        drain();

        // Full valid sweep 00..99
        for (int t = 0; t < 10; t++) begin
            for (int o = 0; o < 10; o++) begin
                go(0, {4'(t), 4'(o)}, t * 10 + o, 0, 0, 43);
                drain();
            end
        end

        // Invalid digits
        go(0, 8'h3A, 0, 1, 0, 2);
        drain();
        go(0, 8'hF9, 0, 1, 0, 2);
        drain();

        // Narrow output: overflow wraps mod 64
        go(1, 8'h99, 35, 0, 1, 37);
        drain();
        go(1, 8'h63, 63, 0, 0, 37);
        drain();
        go(1, 8'h64, 0, 0, 1, 37);
        drain();
        go(1, 8'hA0, 0, 1, 0, 2);
        drain();

        // Reset mid-conversion: no strobe, everything cleared
        bcd7 = 8'h42;
        start7 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start7 = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_zero("midreset");
        @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        go(0, 8'h17, 17, 0, 0, 43);
        drain();

        // Start ignored while busy; operand change ignored
        go(0, 8'h25, 25, 0, 0, 43);
        repeat (4) @(negedge clk);
        bcd7 = 8'h88;
        start7 = 1'b1;
        @(negedge clk);
        start7 = 1'b0;
        n = 0;
        while (dv7 !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("dv_wait_25", int'(dv7), 1);
        // Back-to-back: start issued in the strobe cycle
        go(0, 8'h63, 63, 0, 0, 43);
        drain();
        go(0, 8'h00, 0, 0, 0, 43);
        drain();

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
